// File: rtl/ibex_predecode_buffer.sv
// Instruction FIFO that predecodes each fetched word on enqueue and presents
// the stored class flags, register fields and RV32E range flag for the head entry.
module ibex_predecode_buffer #(
  parameter int unsigned Depth = 4,
  parameter bit          RV32E = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [31:0]                  in_instr_i,
  input  logic [31:0]                  in_pc_i,
  input  logic                         in_err_i,
  input  logic                         flush_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [31:0]                  out_instr_o,
  output logic [31:0]                  out_pc_o,
  output logic                         out_err_o,
  output logic [4:0]                   out_rd_o,
  output logic [4:0]                   out_rs1_o,
  output logic [4:0]                   out_rs2_o,
  output logic                         out_compressed_o,
  output logic                         out_branch_o,
  output logic                         out_jal_o,
  output logic                         out_jalr_o,
  output logic                         out_load_o,
  output logic                         out_store_o,
  output logic                         out_system_o,
  output logic                         out_reg_oob_o,
  output logic [$clog2(Depth+1)-1:0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = $clog2(Depth + 1);

  typedef struct packed {
    logic compressed;
    logic branch;
    logic jal;
    logic jalr;
    logic load;
    logic store;
    logic system;
    logic reg_oob;
  } pd_t;

  // Handshakes: a transfer happens on a cycle where valid && ready are both
  // high at the rising edge; flush_i suppresses both transfers in its cycle.
  logic            push, pop;
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LvlW-1:0] level_q, level_d;
  pd_t             pd_in, pd_head;
  logic [6:0]      opcode;
  logic            use_rd, use_rs1, use_rs2;

  logic [31:0] instr_mem [Depth];
  logic [31:0] pc_mem    [Depth];
  logic        err_mem   [Depth];
  pd_t         pd_mem    [Depth];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign opcode = in_instr_i[6:0];

  always_comb begin
    pd_in      = '0;
    use_rd     = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    pd_in.compressed = (in_instr_i[1:0] != 2'b11);
    if (!pd_in.compressed) begin
      unique case (opcode)
        7'b1100011: pd_in.branch = 1'b1;
        7'b1101111: pd_in.jal    = 1'b1;
        7'b1100111: pd_in.jalr   = 1'b1;
        7'b0000011: pd_in.load   = 1'b1;
        7'b0100011: pd_in.store  = 1'b1;
        7'b1110011: pd_in.system = 1'b1;
        default: ;
      endcase
      use_rd  = opcode inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                               7'b0010111, 7'b1101111, 7'b1100111};
      use_rs1 = opcode inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                               7'b1100011, 7'b1100111};
      use_rs2 = opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
      // Only x16..x31 have bit 4 set, which RV32E does not implement.
      pd_in.reg_oob = RV32E && ((use_rd  && in_instr_i[11]) ||
                                (use_rs1 && in_instr_i[19]) ||
                                (use_rs2 && in_instr_i[24]));
    end
  end

  assign in_ready_o  = (level_q != LvlW'(Depth));
  assign out_valid_o = (level_q != '0);
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      if (push && !pop)      level_d = level_q + LvlW'(1);
      else if (pop && !push) level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Payload storage carries no reset; outputs are masked while empty instead.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wptr_q] <= in_instr_i;
      pc_mem[wptr_q]    <= in_pc_i;
      err_mem[wptr_q]   <= in_err_i;
      pd_mem[wptr_q]    <= pd_in;
    end
  end

  assign out_instr_o = out_valid_o ? instr_mem[rptr_q] : '0;
  assign out_pc_o    = out_valid_o ? pc_mem[rptr_q]    : '0;
  assign out_err_o   = out_valid_o ? err_mem[rptr_q]   : 1'b0;
  assign pd_head     = out_valid_o ? pd_mem[rptr_q]    : '0;

  assign out_rd_o         = out_instr_o[11:7];
  assign out_rs1_o        = out_instr_o[19:15];
  assign out_rs2_o        = out_instr_o[24:20];
  assign out_compressed_o = pd_head.compressed;
  assign out_branch_o     = pd_head.branch;
  assign out_jal_o        = pd_head.jal;
  assign out_jalr_o       = pd_head.jalr;
  assign out_load_o       = pd_head.load;
  assign out_store_o      = pd_head.store;
  assign out_system_o     = pd_head.system;
  assign out_reg_oob_o    = pd_head.reg_oob;
  assign level_o          = level_q;

endmodule

// File: doc/ibex_predecode_buffer.md
IBEX_PREDECODE_BUFFER -- requirements
Module: ibex_predecode_buffer

Interface
REQ-001 SHALL have parameter Depth, default 4, meaning number of instruction entries held (legal range 2..16, any integer).
REQ-002 SHALL have parameter RV32E, default 0, meaning flag register fields >= x16 as out-of-range.
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have ports in_valid_i (input, 1), in_ready_o (output, 1): enqueue handshake.
REQ-006 SHALL have port in_instr_i, input, 32, fetched instruction word (compressed in [15:0] when [1:0]!=2'b11).
REQ-007 SHALL have ports in_pc_i (input, 32) and in_err_i (input, 1), fetch address and fetch bus error.
REQ-008 SHALL have port flush_i, input, 1, discard all entries.
REQ-009 SHALL have ports out_valid_o (output, 1), out_ready_i (input, 1): dequeue handshake.
REQ-010 SHALL have ports out_instr_o (32), out_pc_o (32), out_err_o (1), outputs, head entry payload.
REQ-011 SHALL have outputs out_rd_o, out_rs1_o, out_rs2_o, 5 bits each, instr[11:7], [19:15], [24:20] of head.
REQ-012 SHALL have outputs out_compressed_o, out_branch_o, out_jal_o, out_jalr_o, out_load_o, out_store_o, out_system_o, 1 bit each, predecode class of head.
REQ-013 SHALL have output out_reg_oob_o, 1 bit, RV32E register out-of-range flag of head.
REQ-014 SHALL have output level_o, width $clog2(Depth+1), current entry count.

Function
REQ-015 SHALL compute predecode fields combinationally from in_instr_i at enqueue and store them with the entry; outputs SHALL be registered storage, not recomputed from out_instr_o.
REQ-016 SHALL set compressed = (instr[1:0]!=2'b11); when compressed, all class flags and reg_oob SHALL be 0.
REQ-017 For 32-bit words, class SHALL follow opcode instr[6:0]: 1100011 branch, 1101111 jal, 1100111 jalr, 0000011 load, 0100011 store, 1110011 system; at most one flag set; other opcodes set none.
REQ-018 reg_oob SHALL be 1 only when RV32E=1, not compressed, and: rd[4] with opcode in {0110011,0010011,0000011,0110111,0010111,1101111,1100111}; or rs1[4] with opcode in {0110011,0010011,0000011,0100011,1100011,1100111}; or rs2[4] with opcode in {0110011,0100011,1100011}.
REQ-019 When RV32E=0, reg_oob SHALL be constant 0.
REQ-020 in_ready_o SHALL equal (level_o != Depth) and SHALL NOT depend on out_ready_i or flush_i.
REQ-021 An entry SHALL be written when in_valid_i && in_ready_o && !flush_i; out_valid_o SHALL equal (level_o != 0).
REQ-022 An entry SHALL be removed when out_valid_o && out_ready_i && !flush_i.
REQ-023 No bypass: a word enqueued into an empty buffer SHALL appear on outputs the following cycle (latency 1).
REQ-024 Simultaneous push and pop SHALL leave level_o unchanged and preserve order; allowed at any level 1..Depth-1, and at Depth only the pop occurs.
REQ-025 Read/write pointers SHALL wrap from Depth-1 to 0 for non-power-of-two Depth.
REQ-026 flush_i SHALL have priority: next cycle level_o=0, out_valid_o=0; push and pop in the flush cycle SHALL be ignored.
REQ-027 Head payload outputs SHALL be stable while out_valid_o && !out_ready_i && !flush_i.
REQ-028 When out_valid_o=0, payload outputs are don't-care except predecode flags, which SHALL be 0.

Reset
REQ-029 Asserting rst_ni low SHALL immediately clear level_o to 0, pointers to 0, out_valid_o to 0, in_ready_o to 1, predecode flags to 0; reset mid-operation discards all entries.
REQ-030 Payload storage SHALL need no reset; no output SHALL be X after reset release.

Verification
REQ-031 Push 0x00000463 (beq), pc 0x100 into empty buffer -> next cycle out_valid_o=1, out_branch_o=1, out_pc_o=0x100, level_o=1.
REQ-032 Depth=3: push 4 words with out_ready_i=0 -> in_ready_o=0 after 3rd, 4th not stored; drain -> same 3 in order, level_o 3,2,1,0.
REQ-033 RV32E=1: push 0x01000833 (add x16,x0,x16) -> out_reg_oob_o=1; RV32E=0 same word -> 0.
REQ-034 Level 2, push+pop+flush same cycle -> next cycle level_o=0, out_valid_o=0; push 0x4501 next -> out_compressed_o=1, class flags 0.
REQ-035 Depth=5, 20 random push/pop cycles with pointer wrap -> order and payload match scoreboard; rst_ni low mid-stream -> level_o=0 immediately.
